// File: rtl/dac_tx_pkg.sv
// Shared state encoding and DAC code constants for the transmit framer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dac_tx_pkg;

  // Link bring-up sequence, in the order it is walked after enable rises.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_SYNC  = 2'd2,
    ST_RUN   = 2'd3
  } tx_state_e;

  // Offset-binary mid-scale: the DAC rests here whenever no real sample is sent.
  localparam logic [11:0] MIDSCALE = 12'h800;
  // Training words: alternating bit patterns on the rising/falling lanes.
  localparam logic [11:0] TRAIN_A  = 12'hAAA;
  localparam logic [11:0] TRAIN_B  = 12'h555;

endpackage

// File: rtl/tx_sample_fifo.sv
// Synchronous sample-pair FIFO with flush and occupancy count.
// Latency: a pushed entry is readable on dout_o from the cycle after the push.
// Backpressure: pushes while full are dropped (caller gates with full_o/count_o); pops while empty are ignored.
module tx_sample_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop happens in the same cycle; flush wins over both.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Pointer and occupancy next-state; depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/dac_tx_framer.sv
// DAC LVDS transmit framer: buffers sample pairs, runs idle/train/sync/run bring-up, drives ODDR lanes.
// Latency: pair pushed at edge N into an empty FIFO in RUN appears on dac_d1/dac_d2 after edge N+1.
// Backpressure: s_ready low in IDLE or when the FIFO holds FIFO_DEPTH pairs; an empty FIFO in RUN sends mid-scale and counts underflow.
module dac_tx_framer
  import dac_tx_pkg::*;
#(
  parameter int DATA_W       = 12,
  parameter int FIFO_DEPTH   = 8,
  parameter int TRAIN_CYCLES = 64,
  parameter int FRAME_PERIOD = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                enable,
  input  logic [2*DATA_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                clr_status,
  output logic [DATA_W-1:0]   dac_d1,
  output logic [DATA_W-1:0]   dac_d2,
  output logic                dac_frame,
  output logic                link_up,
  output logic                underflow,
  output logic [15:0]         underflow_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [DATA_W-1:0] MID_W = DATA_W'(MIDSCALE);
  localparam logic [DATA_W-1:0] TA_W  = DATA_W'(TRAIN_A);
  localparam logic [DATA_W-1:0] TB_W  = DATA_W'(TRAIN_B);

  tx_state_e           state_q, state_d;
  logic [15:0]         train_cnt_q, train_cnt_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [DATA_W-1:0]   dac_d1_q, dac_d1_d;
  logic [DATA_W-1:0]   dac_d2_q, dac_d2_d;
  logic                frame_q, frame_d;
  logic                link_q, link_d;
  logic                uf_q, uf_d;
  logic [15:0]         uf_cnt_q, uf_cnt_d;
  logic                uf_ev;

  logic                fifo_push, fifo_pop, fifo_flush;
  logic                fifo_full, fifo_empty;
  logic [2*DATA_W-1:0] fifo_dout;
  logic [CNT_W-1:0]    fifo_cnt;

  // Ready comes straight from registered state and occupancy, so it never depends on s_valid.
  assign s_ready   = (state_q != ST_IDLE) && (fifo_cnt < CNT_W'(FIFO_DEPTH));
  assign fifo_push = s_valid && s_ready && !fifo_full;

  tx_sample_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_n_i (sys_rst_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .din_i   (s_data),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Bring-up sequencing; lane values are decided for the state being entered so they register alongside it.
  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    frame_cnt_d = frame_cnt_q;
    dac_d1_d    = MID_W;
    dac_d2_d    = MID_W;
    frame_d     = 1'b0;
    link_d      = 1'b0;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    uf_ev       = 1'b0;
    if (!enable) begin
      state_d    = ST_IDLE;
      fifo_flush = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_TRAIN;
          train_cnt_d = '0;
          dac_d1_d    = TA_W;
          dac_d2_d    = TB_W;
          frame_d     = 1'b1;
        end
        ST_TRAIN: begin
          if (train_cnt_q == 16'(TRAIN_CYCLES - 1)) begin
            state_d = ST_SYNC;
            frame_d = 1'b1;
          end else begin
            train_cnt_d = train_cnt_q + 16'd1;
            dac_d1_d    = TA_W;
            dac_d2_d    = TB_W;
            // Even training cycles carry the strobe, starting with the first.
            frame_d     = ~train_cnt_d[0];
          end
        end
        ST_SYNC, ST_RUN: begin
          state_d = ST_RUN;
          link_d  = 1'b1;
          if (state_q == ST_SYNC || frame_cnt_q == 16'(FRAME_PERIOD - 1)) frame_cnt_d = '0;
          else                                                            frame_cnt_d = frame_cnt_q + 16'd1;
          frame_d = (frame_cnt_d == '0);
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            dac_d1_d = fifo_dout[DATA_W-1:0];
            dac_d2_d = fifo_dout[2*DATA_W-1:DATA_W];
          end else begin
            uf_ev = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sticky underflow status; a clear coinciding with a new event leaves exactly that event recorded.
  always_comb begin
    uf_d     = uf_q;
    uf_cnt_d = uf_cnt_q;
    if (clr_status) begin
      uf_d     = uf_ev;
      uf_cnt_d = {15'd0, uf_ev};
    end else if (uf_ev) begin
      uf_d = 1'b1;
      if (uf_cnt_q != 16'hFFFF) uf_cnt_d = uf_cnt_q + 16'd1;
    end
  end

  // State, counters, lane and status registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      train_cnt_q <= '0;
      frame_cnt_q <= '0;
      dac_d1_q    <= MID_W;
      dac_d2_q    <= MID_W;
      frame_q     <= 1'b0;
      link_q      <= 1'b0;
      uf_q        <= 1'b0;
      uf_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      dac_d1_q    <= dac_d1_d;
      dac_d2_q    <= dac_d2_d;
      frame_q     <= frame_d;
      link_q      <= link_d;
      uf_q        <= uf_d;
      uf_cnt_q    <= uf_cnt_d;
    end
  end

  assign dac_d1        = dac_d1_q;
  assign dac_d2        = dac_d2_q;
  assign dac_frame     = frame_q;
  assign link_up       = link_q;
  assign underflow     = uf_q;
  assign underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_dac_tx_framer.sv
// Self-checking bench for dac_tx_framer against a queue-based reference model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: model accepts a push only while it holds fewer than DEPTH pairs.
module tb_dac_tx_framer;

  localparam int DW    = 12;
  localparam int DEPTH = 8;
  localparam int TC    = 64;
  localparam int FP    = 16;
  localparam logic [11:0] MID = 12'h800;
  localparam logic [11:0] TA  = 12'hAAA;
  localparam logic [11:0] TB  = 12'h555;

  logic            sys_clk = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic            enable = 1'b0;
  logic [2*DW-1:0] s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic            clr_status = 1'b0;
  logic [DW-1:0]   dac_d1, dac_d2;
  logic            dac_frame, link_up, underflow;
  logic [15:0]     underflow_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  logic [2*DW-1:0] mq[$];
  int              rk;
  logic            m_uf;
  logic [15:0]     m_cnt;
  logic [DW-1:0]   exp_d1, exp_d2;
  logic            exp_frame, exp_rdy, rdy_seen;

  dac_tx_framer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .TRAIN_CYCLES(TC), .FRAME_PERIOD(FP)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .enable        (enable),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .clr_status    (clr_status),
    .dac_d1        (dac_d1),
    .dac_d2        (dac_d2),
    .dac_frame     (dac_frame),
    .link_up       (link_up),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // One RUN-state clock edge: predicts outputs from the model, then advances the DUT.
  task automatic run_edge(input logic v, input logic [2*DW-1:0] d, input logic clr);
    logic ev;
    logic push;
    logic [2*DW-1:0] pr;
    s_valid = v; s_data = d; clr_status = clr;
    rdy_seen = s_ready;
    exp_rdy  = (mq.size() < DEPTH);
    push     = v && exp_rdy;
    ev       = (mq.size() == 0);
    if (!ev) begin
      pr = mq.pop_front();
      exp_d1 = pr[DW-1:0];
      exp_d2 = pr[2*DW-1:DW];
    end else begin
      exp_d1 = MID;
      exp_d2 = MID;
    end
    if (clr) begin
      m_uf  = ev;
      m_cnt = ev ? 16'd1 : 16'd0;
    end else if (ev) begin
      m_uf = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    exp_frame = ((rk % FP) == 0);
    rk++;
    if (push) mq.push_back(d);
    @(posedge sys_clk); #1;
    s_valid = 1'b0; clr_status = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; clr_status = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    n_cmp++;
    if ({dac_d1, dac_d2, dac_frame, link_up, s_ready, underflow, underflow_cnt} !==
        {MID, MID, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_values: got %h %h f%b l%b r%b u%b c%h", dac_d1, dac_d2, dac_frame, link_up, s_ready, underflow, underflow_cnt);
    end
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    n_cmp++;
    if ({dac_d1, dac_d2, dac_frame, link_up, s_ready} !== {MID, MID, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h %h f%b l%b r%b want 800 800 0 0 0", dac_d1, dac_d2, dac_frame, link_up, s_ready);
    end
    mq.delete(); m_uf = 1'b0; m_cnt = 16'd0; rk = 0;
  endtask

  // Enables the link from IDLE, checks every training cycle and the sync cycle, prefilling npush pairs.
  task automatic test_train(input bit seq, input int npush);
    enable = 1'b1;
    @(posedge sys_clk); #1;
    for (int i = 0; i < TC; i++) begin
      n_cmp++;
      if ({dac_d1, dac_d2, dac_frame, link_up} !== {TA, TB, ((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL train_out[%0d]: got %h %h f%b l%b want aaa 555 f%0d l0", i, dac_d1, dac_d2, dac_frame, link_up, (i % 2) == 0);
      end
      if (npush > 0 && i <= npush) begin
        n_cmp++;
        if (s_ready !== (mq.size() < DEPTH)) begin
          n_fail++;
          $display("FAIL train_ready[%0d]: got %b want %b", i, s_ready, mq.size() < DEPTH);
        end
        s_valid = 1'b1;
        s_data  = seq ? {12'(i + 2), 12'(i + 1)} : 24'($urandom);
        if (mq.size() < DEPTH) mq.push_back(s_data);
      end
      @(posedge sys_clk); #1;
      s_valid = 1'b0;
    end
    n_cmp++;
    if ({dac_d1, dac_d2, dac_frame, link_up, underflow, underflow_cnt} !== {MID, MID, 1'b1, 1'b0, m_uf, m_cnt}) begin
      n_fail++;
      $display("FAIL sync_cycle: got %h %h f%b l%b u%b c%h want 800 800 f1 l0 u%b c%h",
               dac_d1, dac_d2, dac_frame, link_up, underflow, underflow_cnt, m_uf, m_cnt);
    end
    rk = 0;
  endtask

  // Prefilled pairs must leave in order from the first RUN cycle, with no underflow.
  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      run_edge(i == DEPTH - 1, 24'($urandom), 1'b0);
      n_cmp++;
      if ({dac_d2, dac_d1, dac_frame, link_up} !== {12'(i + 2), 12'(i + 1), exp_frame, 1'b1}) begin
        n_fail++;
        $display("FAIL drain[%0d]: got %h %h f%b l%b want %h %h f%b l1", i, dac_d1, dac_d2, dac_frame, link_up, 12'(i + 1), 12'(i + 2), exp_frame);
      end
      n_cmp++;
      if ({rdy_seen, underflow} !== {exp_rdy, 1'b0}) begin
        n_fail++;
        $display("FAIL drain_status[%0d]: got r%b u%b want r%b u0", i, rdy_seen, underflow, exp_rdy);
      end
    end
  endtask

  // One pair per cycle in RUN: continuous data, periodic strobe, no underflow.
  task automatic test_stream();
    for (int i = 0; i < 40; i++) begin
      run_edge(1'b1, 24'($urandom), 1'b0);
      n_cmp++;
      if ({dac_d1, dac_d2, dac_frame, link_up, rdy_seen, underflow} !== {exp_d1, exp_d2, exp_frame, 1'b1, exp_rdy, 1'b0}) begin
        n_fail++;
        $display("FAIL stream[%0d]: got %h %h f%b l%b r%b u%b want %h %h f%b l1 r%b u0",
                 i, dac_d1, dac_d2, dac_frame, link_up, rdy_seen, underflow, exp_d1, exp_d2, exp_frame, exp_rdy);
      end
    end
  endtask

  // Three empty cycles give three underflow events; clear coinciding with a fourth leaves a count of one.
  task automatic test_starve();
    run_edge(1'b0, '0, 1'b0);
    n_cmp++;
    if ({dac_d1, dac_d2} !== {exp_d1, exp_d2}) begin
      n_fail++;
      $display("FAIL starve_last_pair: got %h %h want %h %h", dac_d1, dac_d2, exp_d1, exp_d2);
    end
    for (int i = 0; i < 3; i++) begin
      run_edge(1'b0, '0, 1'b0);
      n_cmp++;
      if ({dac_d1, dac_d2, dac_frame, link_up} !== {MID, MID, exp_frame, 1'b1}) begin
        n_fail++;
        $display("FAIL starve_mid[%0d]: got %h %h f%b l%b want 800 800 f%b l1", i, dac_d1, dac_d2, dac_frame, link_up, exp_frame);
      end
    end
    n_cmp++;
    if ({underflow, underflow_cnt} !== {1'b1, 16'd3}) begin
      n_fail++;
      $display("FAIL starve_count: got u%b c%0d want u1 c3", underflow, underflow_cnt);
    end
    run_edge(1'b0, '0, 1'b1);
    n_cmp++;
    if ({underflow, underflow_cnt} !== {1'b1, 16'd1}) begin
      n_fail++;
      $display("FAIL clr_with_event: got u%b c%0d want u1 c1", underflow, underflow_cnt);
    end
  endtask

  // Random valid and occasional clear, compared each cycle against the model.
  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      run_edge($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 15) == 0);
      n_cmp++;
      if ({dac_d1, dac_d2, dac_frame, link_up, rdy_seen, underflow, underflow_cnt} !==
          {exp_d1, exp_d2, exp_frame, 1'b1, exp_rdy, m_uf, m_cnt}) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h %h f%b l%b r%b u%b c%0d want %h %h f%b l1 r%b u%b c%0d",
                 i, dac_d1, dac_d2, dac_frame, link_up, rdy_seen, underflow, underflow_cnt,
                 exp_d1, exp_d2, exp_frame, exp_rdy, m_uf, m_cnt);
      end
    end
  endtask

  // Dropping enable flushes and idles immediately; status survives; re-enable shows no stale data.
  task automatic test_disable();
    enable = 1'b0; s_valid = 1'b1; s_data = 24'($urandom);
    @(posedge sys_clk); #1;
    s_valid = 1'b0;
    mq.delete();
    n_cmp++;
    if ({dac_d1, dac_d2, dac_frame, link_up, s_ready, underflow, underflow_cnt} !== {MID, MID, 1'b0, 1'b0, 1'b0, m_uf, m_cnt}) begin
      n_fail++;
      $display("FAIL disable_idle: got %h %h f%b l%b r%b u%b c%0d want 800 800 0 0 0 u%b c%0d",
               dac_d1, dac_d2, dac_frame, link_up, s_ready, underflow, underflow_cnt, m_uf, m_cnt);
    end
    test_train(1'b0, DEPTH);
    for (int i = 0; i < 4; i++) begin
      run_edge(1'b0, '0, 1'b0);
      n_cmp++;
      if ({dac_d1, dac_d2, link_up} !== {exp_d1, exp_d2, 1'b1}) begin
        n_fail++;
        $display("FAIL predisable_run[%0d]: got %h %h l%b want %h %h l1", i, dac_d1, dac_d2, link_up, exp_d1, exp_d2);
      end
    end
    enable = 1'b0;
    @(posedge sys_clk); #1;
    mq.delete();
    n_cmp++;
    if ({dac_d1, dac_d2, dac_frame, link_up, s_ready, underflow, underflow_cnt} !== {MID, MID, 1'b0, 1'b0, 1'b0, m_uf, m_cnt}) begin
      n_fail++;
      $display("FAIL disable_queued: got %h %h f%b l%b r%b u%b c%0d want 800 800 0 0 0 u%b c%0d",
               dac_d1, dac_d2, dac_frame, link_up, s_ready, underflow, underflow_cnt, m_uf, m_cnt);
    end
    test_train(1'b0, 0);
    run_edge(1'b0, '0, 1'b0);
    n_cmp++;
    if ({dac_d1, dac_d2, dac_frame, link_up, underflow, underflow_cnt} !== {MID, MID, 1'b1, 1'b1, m_uf, m_cnt}) begin
      n_fail++;
      $display("FAIL reenable_no_stale: got %h %h f%b l%b u%b c%0d want 800 800 f1 l1 u%b c%0d",
               dac_d1, dac_d2, dac_frame, link_up, underflow, underflow_cnt, m_uf, m_cnt);
    end
  endtask

  // Reset asserted between edges mid-training must take effect before the next edge.
  task automatic test_async_reset();
    enable = 1'b0;
    @(posedge sys_clk); #1;
    enable = 1'b1; s_valid = 1'b1; s_data = 24'($urandom);
    repeat (5) @(posedge sys_clk);
    #1;
    s_valid = 1'b0;
    n_cmp++;
    if ({dac_d1, link_up, underflow} !== {TA, 1'b0, m_uf}) begin
      n_fail++;
      $display("FAIL pre_reset_train: got %h l%b u%b want aaa l0 u%b", dac_d1, link_up, underflow, m_uf);
    end
    #3;
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dac_d1, dac_d2, dac_frame, link_up, s_ready, underflow, underflow_cnt} !==
        {MID, MID, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL async_reset: got %h %h f%b l%b r%b u%b c%h", dac_d1, dac_d2, dac_frame, link_up, s_ready, underflow, underflow_cnt);
    end
    enable = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    n_cmp++;
    if ({dac_d1, dac_d2, dac_frame, link_up, s_ready} !== {MID, MID, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %h %h f%b l%b r%b", dac_d1, dac_d2, dac_frame, link_up, s_ready);
    end
  endtask

  initial begin
    test_reset();
    test_train(1'b1, DEPTH);
    test_drain();
    test_stream();
    test_starve();
    test_random();
    test_disable();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_tx_framer.md
Name: dac_tx_framer

Overview:
- Transmit-side counterpart of the ADC sampler on the TSW DAC LVDS bus.
- Accepts a stream of sample pairs on sys_clk and buffers them in a small FIFO.
- Runs a link bring-up sequence (idle, training pattern, sync strobe, run) and then presents two 12-bit samples per cycle plus a frame strobe.
- Outputs feed the rising/falling-edge inputs of the top-level ODDRE1/OBUFDS stage, which is outside this block.
- Flags and counts FIFO underflow.

Parameters:
- DATA_W, 12, width of one DAC sample.
- FIFO_DEPTH, 8, sample-pair FIFO entries; must be a power of two, at least 2.
- TRAIN_CYCLES, 64, number of sys_clk cycles the training pattern is sent.
- FRAME_PERIOD, 16, cycles between dac_frame pulses in RUN; at least 2.

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- enable  in  1  link enable; low forces IDLE.
- s_data  in  2*DATA_W  [DATA_W-1:0] = sample N (rising edge), upper half = sample N+1 (falling edge).
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO can accept.
- clr_status  in  1  clears underflow status.
- dac_d1  out  DATA_W  rising-edge sample to ODDR.
- dac_d2  out  DATA_W  falling-edge sample to ODDR.
- dac_frame  out  1  frame/strobe lane to ODDR (driven on both edges).
- link_up  out  1  high while in RUN.
- underflow  out  1  sticky underflow flag.
- underflow_cnt  out  16  saturating underflow event count.

Behaviour:
- Interface: one clock, sys_clk; reset sys_rst_n is asynchronous, active-low. All outputs are registered.
- Reset values:
  - state IDLE, FIFO empty.
  - dac_d1 = dac_d2 = 12'h800 (MIDSCALE); dac_frame 0.
  - link_up 0, s_ready 0, underflow 0, underflow_cnt 0.
- Handshake:
  - A push occurs when s_valid && s_ready.
  - s_ready is 1 when state is not IDLE and the registered FIFO count is below FIFO_DEPTH.
  - When the FIFO is full, no push is accepted even if a pop occurs in the same cycle.
  - A simultaneous push and pop leaves the count unchanged.
- IDLE:
  - Outputs MIDSCALE, dac_frame 0, FIFO held flushed.
  - enable = 1 -> TRAIN on the next edge; the training counter is cleared.
- TRAIN:
  - dac_d1 = 12'hAAA, dac_d2 = 12'h555.
  - dac_frame alternates 1,0,1,0..., starting at 1 on the first TRAIN cycle.
  - Pushes are accepted (prefill), no pops.
  - After exactly TRAIN_CYCLES cycles -> SYNC.
- SYNC:
  - Lasts one cycle: dac_d1 = dac_d2 = MIDSCALE, dac_frame = 1.
  - Frame counter cleared -> RUN.
- RUN:
  - link_up = 1.
  - dac_frame = 1 in the first RUN cycle, then every FRAME_PERIOD cycles, otherwise 0. The frame counter wraps from FRAME_PERIOD-1 to 0.
  - Every cycle: if the FIFO is not empty, pop and register the low half onto dac_d1 and the high half onto dac_d2.
  - If the FIFO is empty, output MIDSCALE on both and raise an underflow event.
- Latency: a pair pushed at edge N into an empty FIFO while in RUN is popped at edge N+1 and is visible on dac_d1/dac_d2 after edge N+1.
- Underflow event:
  - underflow <= 1.
  - underflow_cnt increments and saturates at 16'hFFFF.
- clr_status:
  - Clears underflow and underflow_cnt.
  - If an underflow event occurs in the same cycle, the result is underflow = 1 and underflow_cnt = 1.
- enable low in any state -> IDLE on the next edge:
  - FIFO flushed, outputs return to MIDSCALE, link_up 0 from that edge.
  - Status is retained.
- Reset asserted mid-operation: immediate return to all reset values.
- Data is passed through unchanged; no sign or offset conversion.

Decomposition:
- Package dac_tx_pkg holds:
  - State encoding: IDLE, TRAIN, SYNC, RUN.
  - MIDSCALE = 12'h800, TRAIN_A = 12'hAAA, TRAIN_B = 12'h555.
- Sub-module tx_sample_fifo:
  - Synchronous FIFO, width 2*DATA_W, depth FIFO_DEPTH.
  - Signals: push, pop, flush, full, empty, count.
  - Asynchronous active-low reset.

Test Plan:
- Reset, then enable = 1 with FIFO_DEPTH = 8 and TRAIN_CYCLES = 64 -> exactly 64 cycles of d1 = AAA / d2 = 555 with frame 1,0,...; then one SYNC cycle with frame = 1 and data 800; then link_up = 1.
- Prefill during TRAIN with pairs {001,002}..{008,009}; s_ready falls after the 8th push -> in RUN, outputs appear in order starting from the first RUN cycle, with no underflow.
- Stream in RUN with s_valid held high and one pair per cycle -> continuous data, dac_frame high every 16th cycle, underflow stays 0.
- Starve the FIFO for 3 cycles in RUN -> outputs 800/800 for 3 cycles, underflow = 1, underflow_cnt = 3. Then pulse clr_status in a cycle that is also empty -> underflow = 1, underflow_cnt = 1.
- Drop enable mid-RUN with 4 entries queued -> next edge: IDLE, link_up 0, outputs 800, FIFO empty. Re-enable -> full TRAIN sequence again with no stale data.
- Assert sys_rst_n low asynchronously mid-TRAIN -> all outputs at reset values before the next sys_clk edge.
